jtag_bsr_chain: RTL and testbench
=================================

JTAG_BSR_CHAIN -- requirements
Module: jtag_bsr_chain

Interface
REQ-001 Parameter N_IN, default 1, number of input-pin boundary cells.
REQ-002 Parameter N_OUT, default 4, number of output pins; each pin has one data cell and one enable cell.
REQ-003 tck  input  1  test clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 test_logic_reset  input  1  TAP Test-Logic-Reset indication, synchronous to tck.
REQ-006 capture_dr / shift_dr / update_dr  input  1 each  TAP DR strobes, sampled on tck.
REQ-007 mode  input  2  bsr_mode_t: NORMAL=0, SAMPLE=1, EXTEST=2, INTEST=3.
REQ-008 tdi  input  1; tdo  output  1; tdo_oe  output  1  TDO drive enable.
REQ-009 pin_in  input  N_IN  from input pads; core_in  output  N_IN  to core.
REQ-010 core_out, core_oe  input  N_OUT each  from core; pin_out, pin_oe  output  N_OUT each  to pads.

Function
REQ-011 BSR_WIDTH SHALL be N_IN+2*N_OUT; cells [0..N_IN-1] input, [N_IN..N_IN+N_OUT-1] output data (bit i = pin i), next N_OUT cells output enable.
REQ-012 Scan register SHALL update on tck rising edge; priority test_logic_reset (clear) > capture_dr > shift_dr > hold.
REQ-013 Capture SHALL load pin_in into input cells, core_out into data cells, core_oe into enable cells, in every mode.
REQ-014 Shift SHALL move tdi into cell BSR_WIDTH-1 and shift toward cell 0, one cell per tck.
REQ-015 tdo SHALL be a negedge-tck register loaded with scan cell 0; tdo_oe SHALL be a negedge register loaded with shift_dr.
REQ-016 Update register SHALL load the full scan register on the tck falling edge when update_dr is high; otherwise hold.
REQ-017 test_logic_reset high at a tck rising edge SHALL load the update register with the safe value (all data 0, all enables 0).
REQ-018 NORMAL and SAMPLE: core_in=pin_in, pin_out=core_out, pin_oe=core_oe, combinationally; shifting SHALL not disturb pins.
REQ-019 EXTEST: pin_out/pin_oe SHALL come from the update-register data/enable cells; core_in=pin_in.
REQ-020 Output muxing SHALL be combinational from mode and the update register; a mode change takes effect the same cycle.

Reset
REQ-021 reset_n low SHALL immediately clear scan register, tdo, tdo_oe, and load the update register with the safe value.
REQ-022 reset_n assertion mid-capture/shift/update SHALL abort the operation; the first edge after deassertion starts from reset state.

Configuration
REQ-023 Macro JTAG_BSR_INTEST_EN defined: INTEST SHALL drive core_in from update-register input cells and pin_out/pin_oe from the update register.
REQ-024 JTAG_BSR_INTEST_EN undefined: mode INTEST SHALL behave exactly as NORMAL; no extra logic.

Structure
REQ-025 Package jtag_bsr_pkg SHALL hold bsr_mode_t and the BSR_WIDTH computation function.
REQ-026 One sub-module jtag_bsr_outmux SHALL implement the combinational mode muxing of REQ-018..REQ-020/023.

Verification (N_IN=1, N_OUT=4, BSR_WIDTH=9)
REQ-027 Reset, mode=EXTEST -> pin_oe=0000, pin_out=0000, tdo=0, tdo_oe=0.
REQ-028 SAMPLE, pin_in=1, core_out=1010, core_oe=1111, capture then 9 shifts -> tdo sequence 1,0,1,0,1,1,1,1,1; pins follow core throughout.
REQ-029 EXTEST preload shifting 9'b1111_0110_1 (MSB first into tdi last) then update_dr -> pin_out=0110, pin_oe=1111 only after the falling edge of the update cycle.
REQ-030 capture_dr and shift_dr both high -> capture result loaded, no shift.
REQ-031 reset_n pulsed low after 4 shifts in EXTEST -> scan register 0, pin_oe=0000 immediately.
REQ-032 With JTAG_BSR_INTEST_EN, INTEST, update cell0=1, pin_in=0 -> core_in=1; without macro -> core_in=0.

Source files
------------

// File: rtl/jtag_bsr_pkg.sv
// Shared types and sizing helpers for the JTAG boundary-scan register chain.
package jtag_bsr_pkg;

    typedef enum logic [1:0] {
        BSR_NORMAL = 2'd0,
        BSR_SAMPLE = 2'd1,
        BSR_EXTEST = 2'd2,
        BSR_INTEST = 2'd3
    } bsr_mode_t;

    // Chain length: one cell per input pin, a data and an enable cell per output pin.
    function automatic int unsigned bsr_width(input int unsigned n_in, input int unsigned n_out);
        return n_in + 2 * n_out;
    endfunction

endpackage

// File: rtl/jtag_bsr_chain_if.sv
// TAP-side connection of the boundary-scan chain: DR strobes, mode and serial data.
interface jtag_bsr_chain_if;
    import jtag_bsr_pkg::*;

    logic      test_logic_reset;
    logic      capture_dr;
    logic      shift_dr;
    logic      update_dr;
    bsr_mode_t mode;
    logic      tdi;
    logic      tdo;
    logic      tdo_oe;

    modport master (
        output test_logic_reset, capture_dr, shift_dr, update_dr, mode, tdi,
        input  tdo, tdo_oe
    );

    modport slave (
        input  test_logic_reset, capture_dr, shift_dr, update_dr, mode, tdi,
        output tdo, tdo_oe
    );

endinterface

// File: rtl/jtag_bsr_outmux.sv
// Combinational pad/core steering for the boundary-scan chain.
// JTAG_BSR_INTEST_EN adds INTEST steering; without it INTEST behaves as NORMAL.
module jtag_bsr_outmux
    import jtag_bsr_pkg::*;
#(
    parameter int unsigned N_IN  = 1,
    parameter int unsigned N_OUT = 4
) (
    input  bsr_mode_t          mode,
    input  logic [N_IN-1:0]    pin_in,
`ifdef JTAG_BSR_INTEST_EN
    input  logic [N_IN-1:0]    upd_in,
`endif
    input  logic [N_OUT-1:0]   upd_data,
    input  logic [N_OUT-1:0]   upd_en,
    input  logic [N_OUT-1:0]   core_out,
    input  logic [N_OUT-1:0]   core_oe,
    output logic [N_IN-1:0]    core_in,
    output logic [N_OUT-1:0]   pin_out,
    output logic [N_OUT-1:0]   pin_oe
);

    always_comb begin
        core_in = pin_in;
        pin_out = core_out;
        pin_oe  = core_oe;
        case (mode)
            BSR_EXTEST: begin
                pin_out = upd_data;
                pin_oe  = upd_en;
            end
`ifdef JTAG_BSR_INTEST_EN
            BSR_INTEST: begin
                core_in = upd_in;
                pin_out = upd_data;
                pin_oe  = upd_en;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register: capture/shift chain on rising tck, update latch and TDO on falling tck.
// Optional INTEST steering is enabled with the JTAG_BSR_INTEST_EN macro.
module jtag_bsr_chain
    import jtag_bsr_pkg::*;
#(
    parameter int unsigned N_IN  = 1,
    parameter int unsigned N_OUT = 4
) (
    input  logic               tck,
    input  logic               reset_n,
    jtag_bsr_chain_if.slave    tap,
    input  logic [N_IN-1:0]    pin_in,
    output logic [N_IN-1:0]    core_in,
    input  logic [N_OUT-1:0]   core_out,
    input  logic [N_OUT-1:0]   core_oe,
    output logic [N_OUT-1:0]   pin_out,
    output logic [N_OUT-1:0]   pin_oe
);

    localparam int unsigned BSR_WIDTH = bsr_width(N_IN, N_OUT);
    localparam int unsigned DATA_LSB  = N_IN;
    localparam int unsigned EN_LSB    = N_IN + N_OUT;
    // Input-cell update bits only feed anything when INTEST steering exists.
`ifdef JTAG_BSR_INTEST_EN
    localparam int unsigned UPD_LSB   = 0;
`else
    localparam int unsigned UPD_LSB   = N_IN;
`endif

    logic [BSR_WIDTH-1:0]       scan_q, scan_d;
    logic [BSR_WIDTH-1:UPD_LSB] update_q, update_d;
    logic                       tdo_q, tdo_d;
    logic                       tdo_oe_q, tdo_oe_d;

    always_comb begin
        scan_d = scan_q;
        if (tap.test_logic_reset) begin
            scan_d = '0;
        end else if (tap.capture_dr) begin
            scan_d = {core_oe, core_out, pin_in};
        end else if (tap.shift_dr) begin
            scan_d = {tap.tdi, scan_q[BSR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    // Test-Logic-Reset is held for whole tck cycles, so the falling edge inside
    // the reset cycle forces the safe (all-zero) pad state.
    always_comb begin
        tdo_d    = scan_q[0];
        tdo_oe_d = tap.shift_dr;
        update_d = update_q;
        if (tap.test_logic_reset) begin
            update_d = '0;
        end else if (tap.update_dr) begin
            update_d = scan_q[BSR_WIDTH-1:UPD_LSB];
        end
    end

    always_ff @(negedge tck or negedge reset_n) begin
        if (!reset_n) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
            update_q <= '0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
            update_q <= update_d;
        end
    end

    assign tap.tdo    = tdo_q;
    assign tap.tdo_oe = tdo_oe_q;

    jtag_bsr_outmux #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_outmux (
        .mode     (tap.mode),
        .pin_in   (pin_in),
`ifdef JTAG_BSR_INTEST_EN
        .upd_in   (update_q[N_IN-1:0]),
`endif
        .upd_data (update_q[EN_LSB-1:DATA_LSB]),
        .upd_en   (update_q[BSR_WIDTH-1:EN_LSB]),
        .core_out (core_out),
        .core_oe  (core_oe),
        .core_in  (core_in),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe)
    );

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Directed bench for jtag_bsr_chain (N_IN=1, N_OUT=4) with a TDO scoreboard queue.
module tb_jtag_bsr_chain;
    import jtag_bsr_pkg::*;

    localparam int unsigned N_IN  = 1;
    localparam int unsigned N_OUT = 4;

    logic             tck = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_IN-1:0]  pin_in;
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] core_out;
    logic [N_OUT-1:0] core_oe;
    logic [N_OUT-1:0] pin_out;
    logic [N_OUT-1:0] pin_oe;

    jtag_bsr_chain_if bus();

    jtag_bsr_chain #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .tck      (tck),
        .reset_n  (reset_n),
        .tap      (bus.slave),
        .pin_in   (pin_in),
        .core_in  (core_in),
        .core_out (core_out),
        .core_oe  (core_oe),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe)
    );

    always #5 tck = ~tck;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] cap;
        logic [8:0] pattern;
        logic       e;

        bus.test_logic_reset = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        bus.mode       = BSR_EXTEST;
        bus.tdi        = 1'b0;
        pin_in   = 1'b1;
        core_out = 4'b1010;
        core_oe  = 4'b1111;

        // Reset state in EXTEST
        #3;
        chk("rst_pin_oe",  32'(pin_oe),     32'h0);
        chk("rst_pin_out", 32'(pin_out),    32'h0);
        chk("rst_tdo",     32'(bus.tdo),    32'h0);
        chk("rst_tdo_oe",  32'(bus.tdo_oe), 32'h0);
        chk("rst_core_in", 32'(core_in),    32'h1);
        #9 reset_n = 1'b1;
        tick;

        // SAMPLE: capture then shift the whole chain out
        bus.mode = BSR_SAMPLE;
        tick;
        bus.capture_dr = 1'b1;
        tick;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b1;
        cap = {4'b1111, 4'b1010, 1'b1};
        for (int k = 0; k < 9; k++) exp_q.push_back(cap[k]);
        for (int k = 0; k < 9; k++) begin
            tick;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            chk($sformatf("sample_tdo%0d", k), 32'(bus.tdo), 32'(e));
            chk("sample_tdo_oe",  32'(bus.tdo_oe), 32'h1);
            chk("sample_pin_out", 32'(pin_out), 32'(core_out));
            chk("sample_pin_oe",  32'(pin_oe),  32'(core_oe));
        end
        bus.shift_dr = 1'b0;

        // EXTEST preload and update
        bus.mode = BSR_EXTEST;
        #1;
        chk("extest_pre_pin_oe", 32'(pin_oe), 32'h0);
        pattern = 9'b1111_0110_1;
        bus.shift_dr = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.tdi = pattern[k];
            tick;
            chk("extest_shift_pin_oe", 32'(pin_oe), 32'h0);
        end
        bus.shift_dr  = 1'b0;
        bus.update_dr = 1'b1;
        #3;
        chk("extest_before_fall_pin_out", 32'(pin_out), 32'h0);
        chk("extest_before_fall_pin_oe",  32'(pin_oe),  32'h0);
        @(negedge tck);
        #1;
        chk("extest_upd_pin_out", 32'(pin_out), 32'b0110);
        chk("extest_upd_pin_oe",  32'(pin_oe),  32'b1111);
        chk("extest_core_in",     32'(core_in), 32'(pin_in));
        tick;
        bus.update_dr = 1'b0;

        // capture_dr and shift_dr together: capture wins
        core_out = 4'b0101;
        core_oe  = 4'b0011;
        pin_in   = 1'b0;
        bus.tdi  = 1'b1;
        bus.capture_dr = 1'b1;
        bus.shift_dr   = 1'b1;
        tick;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b1;
        @(negedge tck);
        #1;
        chk("capshift_pin_out", 32'(pin_out), 32'b0101);
        chk("capshift_pin_oe",  32'(pin_oe),  32'b0011);
        tick;
        bus.update_dr = 1'b0;

        // Mode change is combinational
        bus.mode = BSR_NORMAL;
        core_out = 4'b1100;
        core_oe  = 4'b1000;
        #1;
        chk("normal_pin_out", 32'(pin_out), 32'b1100);
        chk("normal_pin_oe",  32'(pin_oe),  32'b1000);
        bus.mode = BSR_EXTEST;
        #1;
        chk("back_extest_pin_out", 32'(pin_out), 32'b0101);

        // Asynchronous reset in the middle of a shift
        bus.tdi = 1'b1;
        bus.shift_dr = 1'b1;
        repeat (4) tick;
        reset_n = 1'b0;
        #1;
        chk("midrst_pin_oe",  32'(pin_oe),     32'h0);
        chk("midrst_pin_out", 32'(pin_out),    32'h0);
        chk("midrst_tdo",     32'(bus.tdo),    32'h0);
        chk("midrst_tdo_oe",  32'(bus.tdo_oe), 32'h0);
        bus.shift_dr = 1'b0;
        #1 reset_n = 1'b1;
        bus.update_dr = 1'b1;
        @(negedge tck);
        #1;
        chk("midrst_scan_clear_oe",  32'(pin_oe),  32'h0);
        chk("midrst_scan_clear_out", 32'(pin_out), 32'h0);
        tick;
        bus.update_dr = 1'b0;

        // Test-Logic-Reset forces the safe update value and clears the chain
        core_out = 4'b1111;
        core_oe  = 4'b1111;
        bus.capture_dr = 1'b1;
        tick;
        bus.capture_dr = 1'b0;
        bus.update_dr  = 1'b1;
        @(negedge tck);
        #1;
        chk("tlr_pre_pin_oe", 32'(pin_oe), 32'b1111);
        tick;
        bus.update_dr = 1'b0;
        bus.test_logic_reset = 1'b1;
        tick;
        chk("tlr_pin_oe",  32'(pin_oe),  32'h0);
        chk("tlr_pin_out", 32'(pin_out), 32'h0);
        bus.test_logic_reset = 1'b0;
        bus.update_dr = 1'b1;
        @(negedge tck);
        #1;
        chk("tlr_scan_clear_oe", 32'(pin_oe), 32'h0);
        tick;
        bus.update_dr = 1'b0;

        // INTEST steering
        pin_in   = 1'b1;
        core_out = 4'b0011;
        core_oe  = 4'b0110;
        bus.capture_dr = 1'b1;
        tick;
        bus.capture_dr = 1'b0;
        bus.update_dr  = 1'b1;
        @(negedge tck);
        tick;
        bus.update_dr = 1'b0;
        pin_in   = 1'b0;
        core_out = 4'b1001;
        core_oe  = 4'b1111;
        bus.mode = BSR_INTEST;
        #1;
`ifdef JTAG_BSR_INTEST_EN
        chk("intest_core_in", 32'(core_in), 32'h1);
        chk("intest_pin_out", 32'(pin_out), 32'b0011);
        chk("intest_pin_oe",  32'(pin_oe),  32'b0110);
`else
        chk("intest_core_in", 32'(core_in), 32'h0);
        chk("intest_pin_out", 32'(pin_out), 32'b1001);
        chk("intest_pin_oe",  32'(pin_oe),  32'b1111);
`endif
        bus.mode = BSR_NORMAL;
        #1;
        chk("final_normal_core_in", 32'(core_in), 32'h0);
        chk("final_normal_pin_out", 32'(pin_out), 32'b1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
